// File: rtl/fast_multiplier.sv
// Signed WIDTH x WIDTH multiplier: Baugh-Wooley partial products, carry-save
// reduction tree, one final adder, result and overflow flag registered once.
module fast_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  input  logic [WIDTH-1:0] multiplicand_in,
  input  logic [WIDTH-1:0] multiplier_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] product_out,
  output logic             overflow_out,
  output logic             valid_out
);

  localparam int PW    = 2 * WIDTH;
  localparam int ROWS0 = WIDTH + 1;

  // Rows left after a given number of 3:2 compression levels.
  function automatic int rowsAt(input int level);
    int n;
    n = ROWS0;
    for (int i = 0; i < level; i++) n = n - n / 3;
    return n;
  endfunction

  function automatic int levelCount();
    int n;
    int l;
    n = ROWS0;
    l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = levelCount();

  logic [PW-1:0]    w_rows [0:LEVELS][0:WIDTH];
  logic [PW-1:0]    w_full;
  logic [WIDTH:0]   w_upper;
  logic             w_overflow;
  logic [WIDTH-1:0] r_product;
  logic             r_overflow;
  logic             r_valid;

  // Sign-bit products are inverted; the two constant ones fold in the correction.
  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_pp
    assign w_rows[0][i] = {{WIDTH{1'b0}},
                           ~(multiplicand_in[WIDTH-1] & multiplier_in[i]),
                           multiplicand_in[WIDTH-2:0] & {(WIDTH-1){multiplier_in[i]}}} << i;
  end

  assign w_rows[0][WIDTH-1] = {{WIDTH{1'b0}},
                               multiplicand_in[WIDTH-1] & multiplier_in[WIDTH-1],
                               ~(multiplicand_in[WIDTH-2:0] & {(WIDTH-1){multiplier_in[WIDTH-1]}})}
                              << (WIDTH - 1);

  assign w_rows[0][WIDTH] = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NIN  = rowsAt(l - 1);
    localparam int NG   = NIN / 3;
    localparam int NOUT = rowsAt(l);

    for (genvar k = 0; k < NG; k++) begin : g_csa
      assign w_rows[l][2*k]   = w_rows[l-1][3*k] ^ w_rows[l-1][3*k+1] ^ w_rows[l-1][3*k+2];
      assign w_rows[l][2*k+1] = ((w_rows[l-1][3*k]   & w_rows[l-1][3*k+1]) |
                                 (w_rows[l-1][3*k]   & w_rows[l-1][3*k+2]) |
                                 (w_rows[l-1][3*k+1] & w_rows[l-1][3*k+2])) << 1;
    end

    for (genvar k = 0; k < NIN - 3 * NG; k++) begin : g_pass
      assign w_rows[l][2*NG+k] = w_rows[l-1][3*NG+k];
    end

    for (genvar k = NOUT; k <= WIDTH; k++) begin : g_zero
      assign w_rows[l][k] = '0;
    end
  end

  assign w_full     = w_rows[LEVELS][0] + w_rows[LEVELS][1];
  assign w_upper    = w_full[PW-1:WIDTH-1];
  assign w_overflow = !((&w_upper) || !(|w_upper));

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_product  <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_product  <= w_full[WIDTH-1:0];
      r_overflow <= w_overflow;
      r_valid    <= valid_in;
    end
  end

  assign product_out  = r_product;
  assign overflow_out = r_overflow;
  assign valid_out    = r_valid;

endmodule

// File: tb/tb_fast_multiplier.sv
// Scoreboard bench for fast_multiplier: driver pushes expected results,
// a monitor pops and compares one entry per clock edge.
module tb_fast_multiplier;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] product;
    logic         overflow;
    logic         valid;
  } exp_t;

  logic         clock_in;
  logic         reset_n_in;
  logic [W-1:0] multiplicand_in;
  logic [W-1:0] multiplier_in;
  logic         valid_in;
  logic [W-1:0] product_out;
  logic         overflow_out;
  logic         valid_out;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  fast_multiplier #(.WIDTH(W)) dut (
    .clock_in       (clock_in),
    .reset_n_in     (reset_n_in),
    .multiplicand_in(multiplicand_in),
    .multiplier_in  (multiplier_in),
    .valid_in       (valid_in),
    .product_out    (product_out),
    .overflow_out   (overflow_out),
    .valid_out      (valid_out)
  );

  initial clock_in = 1'b0;
  always #10 clock_in = ~clock_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed product, truncated, overflow by range test.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    exp_t   e;
    longint pa, pb, full;
    pa   = longint'($signed(a));
    pb   = longint'($signed(b));
    full = pa * pb;
    e.product  = full[W-1:0];
    e.overflow = (full < -(longint'(1) << (W - 1))) || (full > (longint'(1) << (W - 1)) - 1);
    e.valid    = v;
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    exp_t e;
    @(negedge clock_in);
    multiplicand_in = a;
    multiplier_in   = b;
    valid_in        = v;
    if (!reset_n_in) begin
      e.product = '0; e.overflow = 1'b0; e.valid = 1'b0;
    end else begin
      e = model(a, b, v);
    end
    expQ.push_back(e);
  endtask

  task automatic applyDirected(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] p, input logic ov);
    exp_t e;
    @(negedge clock_in);
    multiplicand_in = a;
    multiplier_in   = b;
    valid_in        = 1'b1;
    e.product = p; e.overflow = ov; e.valid = 1'b1;
    expQ.push_back(e);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_product"},  32'(product_out),  32'h0);
    checkOutput({tag, "_overflow"}, 32'(overflow_out), 32'h0);
    checkOutput({tag, "_valid"},    32'(valid_out),    32'h0);
  endtask

  // Monitor: every edge yields exactly one expected response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock_in);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("product",  32'(product_out),  32'(e.product));
        checkOutput("overflow", 32'(overflow_out), 32'(e.overflow));
        checkOutput("valid",    32'(valid_out),    32'(e.valid));
      end
    end
  end

  initial begin
    logic [W-1:0] da [9];
    logic [W-1:0] db [9];
    logic [W-1:0] dp [9];
    logic         dov [9];
    bit           drained;

    da = '{16'h0003, 16'hFFFC, 16'hFFFF, 16'h0100, 16'h00B5, 16'h8000, 16'h8000, 16'h8000, 16'h0000};
    db = '{16'h0005, 16'h0006, 16'hFFFF, 16'h0080, 16'h00B5, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000};
    dp = '{16'h000F, 16'hFFE8, 16'h0001, 16'h8000, 16'h7FF9, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
    dov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reset_n_in      = 1'b0;
    multiplicand_in = 16'h1234;
    multiplier_in   = 16'h5678;
    valid_in        = 1'b1;
    #1;
    checkZeroOutputs("async_reset");

    for (int i = 0; i < 3; i++)
      applyStimulus(W'($urandom), W'($urandom), 1'b1);

    @(negedge clock_in);
    reset_n_in = 1'b1;
    multiplicand_in = da[0];
    multiplier_in   = db[0];
    valid_in        = 1'b1;
    expQ.push_back('{product: dp[0], overflow: dov[0], valid: 1'b1});

    for (int i = 1; i < 9; i++)
      applyDirected(da[i], db[i], dp[i], dov[i]);

    applyStimulus(W'($urandom), W'($urandom), 1'b0);
    applyStimulus(W'($urandom), W'($urandom), 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b1);

    for (int i = 0; i < 1000; i++)
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0));

    // Async pulse between edges: outputs clear at once and stay clear until the next edge.
    @(posedge clock_in);
    #2 reset_n_in = 1'b0;
    #1 checkZeroOutputs("midreset");
    #2 reset_n_in = 1'b1;
    #1 checkZeroOutputs("post_release");

    applyStimulus(16'h7FFF, 16'h7FFF, 1'b1);
    for (int i = 0; i < 50; i++)
      applyStimulus(W'($urandom), W'($urandom), 1'b1);

    drained = 1'b0;
    for (int i = 0; i < 10 && !drained; i++) begin
      @(posedge clock_in);
      #2;
      if (expQ.size() == 0) drained = 1'b1;
    end
    if (!drained) checkOutput("drain_timeout", 32'(expQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
